// File: rtl/ook_frame_tx.sv
// On-off keying frame transmitter: sync preamble, pulse-width coded data bits
// and inter-frame gaps, all timed in chips of SYM_DIV ref_clk cycles.
module ook_frame_tx #(
    parameter int FRAME_BITS    = 32,
    parameter int SYM_DIV       = 3600,
    parameter int CHIPS_PER_BIT = 3,
    parameter int ONE_CHIPS     = 2,
    parameter int ZERO_CHIPS    = 1,
    parameter int SYNC_HIGH     = 1,
    parameter int SYNC_LOW      = 10,
    parameter int GAP_CHIPS     = 30
) (
    input  logic                            ref_clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [FRAME_BITS-1:0]           frame,
    input  logic [$clog2(FRAME_BITS+1)-1:0] frame_len,
    input  logic [7:0]                      repeats,
    output logic                            ook,
    output logic                            sending,
    output logic                            done
);
    localparam int LEN_W      = $clog2(FRAME_BITS + 1);
    localparam int PRE_W      = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int SYNC_CHIPS = SYNC_HIGH + SYNC_LOW;
    localparam int MAX_A      = (SYNC_CHIPS > CHIPS_PER_BIT) ? SYNC_CHIPS : CHIPS_PER_BIT;
    localparam int CHIP_MAX   = (MAX_A > GAP_CHIPS) ? MAX_A : GAP_CHIPS;
    localparam int CHIP_W     = $clog2(CHIP_MAX + 1);

    localparam logic [LEN_W-1:0]  FB_L        = LEN_W'(FRAME_BITS);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(SYM_DIV - 1);
    localparam logic [CHIP_W-1:0] SYNC_HI_L   = CHIP_W'(SYNC_HIGH);
    localparam logic [CHIP_W-1:0] SYNC_LAST   = CHIP_W'(SYNC_CHIPS - 1);
    localparam logic [CHIP_W-1:0] BIT_LAST    = CHIP_W'(CHIPS_PER_BIT - 1);
    localparam logic [CHIP_W-1:0] GAP_LAST    = CHIP_W'(GAP_CHIPS - 1);
    localparam logic [CHIP_W-1:0] ONE_L       = CHIP_W'(ONE_CHIPS);
    localparam logic [CHIP_W-1:0] ZERO_L      = CHIP_W'(ZERO_CHIPS);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t                 state;
    logic [PRE_W-1:0]       presc;
    logic [CHIP_W-1:0]      chip_cnt;
    logic [LEN_W-1:0]       bits_left;
    logic [LEN_W-1:0]       len_q;
    logic [7:0]             rep_cnt;
    logic [FRAME_BITS-1:0]  frame_q;
    logic [FRAME_BITS-1:0]  data_sh;

    logic [LEN_W-1:0]       len_c;
    logic [FRAME_BITS-1:0]  frame_al;
    logic                   chip_last;
    logic [CHIP_W-1:0]      chip_nx;
    logic [CHIP_W-1:0]      high_chips;

    // Frames are stored MSB-aligned so the current data bit is always the top bit.
    assign len_c      = (frame_len > FB_L) ? FB_L : frame_len;
    assign frame_al   = frame << (FB_L - len_c);
    assign chip_last  = (presc == PRE_LAST);
    assign chip_nx    = chip_cnt + 1'b1;
    assign high_chips = data_sh[FRAME_BITS-1] ? ONE_L : ZERO_L;

    // Request/completion: start is taken on any edge where the block is idle and
    // frame_len is nonzero; done pulses once, on the cycle sending drops after a
    // full transmission, and a new start may be presented in that same cycle.
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            chip_cnt  <= '0;
            bits_left <= '0;
            len_q     <= '0;
            rep_cnt   <= '0;
            frame_q   <= '0;
            data_sh   <= '0;
            ook       <= 1'b0;
            sending   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                ook <= 1'b0;
                if (start && frame_len != '0) begin
                    state    <= SYNC;
                    presc    <= '0;
                    chip_cnt <= '0;
                    frame_q  <= frame_al;
                    len_q    <= len_c;
                    rep_cnt  <= (repeats == 8'd0) ? 8'd1 : repeats;
                    ook      <= 1'b1;
                    sending  <= 1'b1;
                end
            end else if (abort) begin
                state    <= IDLE;
                presc    <= '0;
                chip_cnt <= '0;
                ook      <= 1'b0;
                sending  <= 1'b0;
            end else begin
                presc <= chip_last ? '0 : presc + 1'b1;
                if (chip_last) begin
                    case (state)
                        SYNC: begin
                            if (chip_cnt == SYNC_LAST) begin
                                state     <= DATA;
                                chip_cnt  <= '0;
                                bits_left <= len_q;
                                data_sh   <= frame_q;
                                ook       <= frame_q[FRAME_BITS-1] ? (ONE_L != '0) : (ZERO_L != '0);
                            end else begin
                                chip_cnt <= chip_nx;
                                ook      <= (chip_nx < SYNC_HI_L);
                            end
                        end
                        DATA: begin
                            if (chip_cnt == BIT_LAST) begin
                                chip_cnt <= '0;
                                if (bits_left == LEN_W'(1)) begin
                                    ook <= 1'b0;
                                    if (rep_cnt > 8'd1) begin
                                        state   <= GAP;
                                        rep_cnt <= rep_cnt - 8'd1;
                                    end else begin
                                        state   <= IDLE;
                                        sending <= 1'b0;
                                        done    <= 1'b1;
                                    end
                                end else begin
                                    bits_left <= bits_left - 1'b1;
                                    data_sh   <= data_sh << 1;
                                    ook       <= data_sh[FRAME_BITS-2] ? (ONE_L != '0) : (ZERO_L != '0);
                                end
                            end else begin
                                chip_cnt <= chip_nx;
                                ook      <= (chip_nx < high_chips);
                            end
                        end
                        GAP: begin
                            if (chip_cnt == GAP_LAST) begin
                                state    <= SYNC;
                                chip_cnt <= '0;
                                ook      <= 1'b1;
                            end else begin
                                chip_cnt <= chip_nx;
                                ook      <= 1'b0;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            ook     <= 1'b0;
                            sending <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ook_frame_tx.sv
// Directed bench for ook_frame_tx: table of frames checked chip-by-chip against
// an expected-ook queue, plus abort, zero-length, chained-start and reset sequences.
module tb_ook_frame_tx;
    localparam int LIMIT = 3000;

    logic        ref_clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] frame;
    logic [4:0]  frame_len;
    logic [7:0]  repeats;
    logic        ook;
    logic        sending;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [15:0] frame;
        logic [4:0]  len;
        logic [7:0]  reps;
        int          exp_cycles;
        bit          disturb;
        bit          chain;
        bit          prestarted;
    } vec_t;

    vec_t vecs[8];

    ook_frame_tx #(
        .FRAME_BITS(16), .SYM_DIV(4), .CHIPS_PER_BIT(3), .ONE_CHIPS(2), .ZERO_CHIPS(1),
        .SYNC_HIGH(1), .SYNC_LOW(2), .GAP_CHIPS(5)
    ) dut (
        .ref_clk(ref_clk), .reset_n(reset_n), .start(start), .abort(abort),
        .frame(frame), .frame_len(frame_len), .repeats(repeats),
        .ook(ook), .sending(sending), .done(done)
    );

    // clock / reset
    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_chip(input logic v);
        repeat (4) exp_q.push_back(v);
    endtask

    // Expected ook stream: sync 1H 2L, per bit 3 chips with 2H (one) or 1H (zero), 5L gaps.
    task automatic build_exp(input logic [15:0] f, input int l, input int r);
        int n;
        int reps;
        int hi;
        n    = (l > 16) ? 16 : l;
        reps = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int rp = 0; rp < reps; rp++) begin
            if (rp > 0) repeat (5) push_chip(1'b0);
            push_chip(1'b1);
            push_chip(1'b0);
            push_chip(1'b0);
            for (int b = n - 1; b >= 0; b--) begin
                hi = f[b] ? 2 : 1;
                for (int c = 0; c < 3; c++) push_chip(c < hi);
            end
        end
    endtask

    // driver: present a start pulse; returns at the first sample after acceptance
    task automatic drive_start(input logic [15:0] f, input logic [4:0] l, input logic [7:0] r);
        @(negedge ref_clk);
        frame     = f;
        frame_len = l;
        repeats   = r;
        start     = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
    endtask

    task automatic monitor(input int exp_cycles, input bit disturb, input bit chain);
        int cyc;
        int bad;
        int timeout;
        logic [0:0] e;
        cyc = 0;
        bad = 0;
        timeout = 0;
        while (sending === 1'b1) begin
            cyc++;
            if (exp_q.size() == 0) bad++;
            else begin
                e = exp_q.pop_front();
                if (ook !== e[0]) bad++;
            end
            if (disturb && cyc == 20) begin
                start     = 1'b1;
                frame     = ~frame;
                frame_len = 5'd7;
                repeats   = 8'd4;
            end
            if (disturb && cyc == 21) start = 1'b0;
            if (cyc >= LIMIT) begin
                timeout = 1;
                break;
            end
            @(negedge ref_clk);
        end
        check("timeout", timeout, 0);
        check("ook_pattern", bad, 0);
        check("exp_left", exp_q.size(), 0);
        check("sending_cycles", cyc, exp_cycles);
        check("done_at_fall", int'(done), 1);
        if (chain) begin
            start = 1'b1;
            @(negedge ref_clk);
            start = 1'b0;
            check("chain_accept", int'(sending), 1);
        end else begin
            @(negedge ref_clk);
            check("done_single", int'(done), 0);
        end
    endtask

    initial begin
        int cnt_s;
        int cnt_d;
        vecs[0] = '{16'h0005, 5'd3,  8'd1, 48,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 5'd3,  8'd2, 116, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'hA5C3, 5'd20, 8'd1, 204, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0002, 5'd2,  8'd0, 36,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8001, 5'd16, 8'd3, 652, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 5'd3,  8'd1, 48,  1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h00F0, 5'd8,  8'd1, 108, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h00F0, 5'd8,  8'd1, 108, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        frame = '0; frame_len = '0; repeats = '0;
        repeat (3) @(posedge ref_clk);
        @(negedge ref_clk);
        check("reset_ook", int'(ook), 0);
        check("reset_sending", int'(sending), 0);
        check("reset_done", int'(done), 0);
        reset_n = 1'b1;

        // abort in the 10th DATA cycle (sync occupies cycles 1..12)
        drive_start(16'h0005, 5'd3, 8'd1);
        repeat (21) @(negedge ref_clk);
        abort = 1'b1;
        @(negedge ref_clk);
        abort = 1'b0;
        check("abort_ook", int'(ook), 0);
        check("abort_sending", int'(sending), 0);
        check("abort_done", int'(done), 0);
        cnt_d = 0;
        repeat (20) begin
            @(negedge ref_clk);
            if (done === 1'b1) cnt_d++;
        end
        check("abort_no_done", cnt_d, 0);

        for (int i = 0; i < 8; i++) begin
            build_exp(vecs[i].frame, int'(vecs[i].len), int'(vecs[i].reps));
            if (!vecs[i].prestarted) drive_start(vecs[i].frame, vecs[i].len, vecs[i].reps);
            monitor(vecs[i].exp_cycles, vecs[i].disturb, vecs[i].chain);
        end

        // zero-length start is ignored
        @(negedge ref_clk);
        frame = 16'h0005; frame_len = 5'd0; repeats = 8'd1; start = 1'b1;
        cnt_s = 0; cnt_d = 0;
        repeat (10) begin
            @(negedge ref_clk);
            if (sending === 1'b1) cnt_s++;
            if (done === 1'b1) cnt_d++;
        end
        start = 1'b0;
        check("len0_sending", cnt_s, 0);
        check("len0_done", cnt_d, 0);

        // asynchronous reset in the middle of the gap (cycles 49..68)
        drive_start(16'h0005, 5'd3, 8'd2);
        repeat (54) @(negedge ref_clk);
        check("pre_reset_sending", int'(sending), 1);
        reset_n = 1'b0;
        #1;
        check("async_ook", int'(ook), 0);
        check("async_sending", int'(sending), 0);
        check("async_done", int'(done), 0);
        @(negedge ref_clk);
        reset_n = 1'b1;
        cnt_s = 0; cnt_d = 0;
        repeat (100) begin
            @(negedge ref_clk);
            if (sending === 1'b1) cnt_s++;
            if (done === 1'b1) cnt_d++;
        end
        check("post_reset_sending", cnt_s, 0);
        check("post_reset_done", cnt_d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
